// File: rtl/round_robin_src_4x1_if.sv
// Bus bundle between the four input FIFOs, the downstream demux_4x1 and
// the round-robin source. The slave modport is the arbiter's view of it.
interface round_robin_src_4x1_if;
  logic [3:0] fifo_empty;
  logic [9:0] fifo_data_0;
  logic [9:0] fifo_data_1;
  logic [9:0] fifo_data_2;
  logic [9:0] fifo_data_3;
  logic [3:0] dest_almost_full;
  logic [3:0] fifo_pop;
  logic [9:0] demuxIn;
  logic [1:0] select;
  logic       valid;
  logic [1:0] grant_id;

  modport slave (
    input  fifo_empty,
    input  fifo_data_0,
    input  fifo_data_1,
    input  fifo_data_2,
    input  fifo_data_3,
    input  dest_almost_full,
    output fifo_pop,
    output demuxIn,
    output select,
    output valid,
    output grant_id
  );

  modport master (
    output fifo_empty,
    output fifo_data_0,
    output fifo_data_1,
    output fifo_data_2,
    output fifo_data_3,
    output dest_almost_full,
    input  fifo_pop,
    input  demuxIn,
    input  select,
    input  valid,
    input  grant_id
  );
endinterface

// File: rtl/round_robin_src_4x1.sv
// Four-input round-robin source feeding a demux_4x1; one word per cycle.
// Optional macro RR_BACKPRESSURE_EN: skip inputs whose destination is almost full.
module round_robin_src_4x1 (
  input  logic                   clk,
  input  logic                   reset,
  round_robin_src_4x1_if.slave   bus
);

  logic [9:0] w_head [4];
  logic [3:0] w_eligible;
  logic [1:0] w_cand;
  logic [1:0] w_grant_idx;
  logic       w_grant_any;
  logic [3:0] w_pop;

  logic [1:0] r_last_grant;
  logic [9:0] r_demux_in;
  logic [1:0] r_select;
  logic       r_valid;
  logic [1:0] r_grant_id;

  assign w_head[0] = bus.fifo_data_0;
  assign w_head[1] = bus.fifo_data_1;
  assign w_head[2] = bus.fifo_data_2;
  assign w_head[3] = bus.fifo_data_3;

  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < 4; i++) begin
`ifdef RR_BACKPRESSURE_EN
      w_eligible[i] = !bus.fifo_empty[i] && !bus.dest_almost_full[w_head[i][9:8]];
`else
      w_eligible[i] = !bus.fifo_empty[i];
`endif
    end
  end

  // Scan last_grant+1 .. last_grant+4; k==4 wraps back to last_grant itself.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = r_last_grant;
    w_cand      = '0;
    for (int k = 1; k <= 4; k++) begin
      w_cand = r_last_grant + 2'(k);
      if (!w_grant_any && w_eligible[w_cand]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  always_comb begin
    w_pop = '0;
    if (reset && w_grant_any) begin
      w_pop[w_grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last_grant <= 2'd3;
      r_demux_in   <= '0;
      r_select     <= '0;
      r_valid      <= 1'b0;
      r_grant_id   <= '0;
    end else if (w_grant_any) begin
      r_last_grant <= w_grant_idx;
      r_demux_in   <= w_head[w_grant_idx];
      r_select     <= w_head[w_grant_idx][9:8];
      r_valid      <= 1'b1;
      r_grant_id   <= w_grant_idx;
    end else begin
      r_valid      <= 1'b0;
    end
  end

  assign bus.fifo_pop = w_pop;
  assign bus.demuxIn  = r_demux_in;
  assign bus.select   = r_select;
  assign bus.valid    = r_valid;
  assign bus.grant_id = r_grant_id;

endmodule

// File: tb/tb_round_robin_src_4x1.sv
// Scoreboard bench for round_robin_src_4x1: directed vectors queue their
// expected pop strobe and registered outputs; a negedge monitor compares.
module tb_round_robin_src_4x1;

  logic clk;
  logic reset;

  round_robin_src_4x1_if bus ();

  round_robin_src_4x1 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pop;
    logic       v;
    logic [9:0] w;
    logic [1:0] s;
    logic [1:0] g;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks;
  int   n_fail;

  task automatic chk(input string n, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, expv);
    end
  endtask

  // Inputs are applied 1 time unit after a rising edge; the expected record
  // describes what the monitor must see at the following falling edge.
  task automatic vec(input logic rst, input logic [3:0] empty,
                     input logic [9:0] d0, input logic [9:0] d1,
                     input logic [9:0] d2, input logic [9:0] d3,
                     input logic [3:0] afull, input logic [3:0] e_pop,
                     input logic e_v, input logic [9:0] e_w,
                     input logic [1:0] e_s, input logic [1:0] e_g,
                     input string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset                = rst;
    bus.fifo_empty       = empty;
    bus.fifo_data_0      = d0;
    bus.fifo_data_1      = d1;
    bus.fifo_data_2      = d2;
    bus.fifo_data_3      = d3;
    bus.dest_almost_full = afull;
    e.pop  = e_pop;
    e.v    = e_v;
    e.w    = e_w;
    e.s    = e_s;
    e.g    = e_g;
    e.name = name;
    sb_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk({e.name, ".pop"},      int'(bus.fifo_pop), int'(e.pop));
        chk({e.name, ".onehot"},   int'($countones(bus.fifo_pop) <= 1), 1);
        chk({e.name, ".valid"},    int'(bus.valid),    int'(e.v));
        chk({e.name, ".demuxIn"},  int'(bus.demuxIn),  int'(e.w));
        chk({e.name, ".select"},   int'(bus.select),   int'(e.s));
        chk({e.name, ".grant_id"}, int'(bus.grant_id), int'(e.g));
      end
    end
  end

  localparam logic [9:0] H0  = 10'h000;
  localparam logic [9:0] H1  = 10'h100;
  localparam logic [9:0] H2  = 10'h200;
  localparam logic [9:0] H3  = 10'h300;
  localparam logic [9:0] W28 = 10'b1001111001;
  localparam logic [9:0] W29 = 10'b1011001100;
  localparam logic [9:0] B0  = 10'h3A5;
  localparam logic [9:0] B1  = 10'h05A;

  initial begin : stim
    bit drained;
    n_checks = 0;
    n_fail   = 0;
    reset                = 1'b0;
    bus.fifo_empty       = 4'b0000;
    bus.fifo_data_0      = H0;
    bus.fifo_data_1      = H1;
    bus.fifo_data_2      = H2;
    bus.fifo_data_3      = H3;
    bus.dest_almost_full = 4'b0000;

    //  rst  empty    d0   d1   d2   d3    afull    pop      v  word  sel  gid
    vec(0, 4'b0000, H0,  H1,  H2,  H3,  4'b0000, 4'b0000, 0, H0,  0, 0, "rst_a");
    vec(0, 4'b0000, H0,  H1,  H2,  H3,  4'b0000, 4'b0000, 0, H0,  0, 0, "rst_b");
    vec(1, 4'b0000, H0,  H1,  H2,  H3,  4'b0000, 4'b0001, 0, H0,  0, 0, "rr_0");
    vec(1, 4'b0000, H0,  H1,  H2,  H3,  4'b0000, 4'b0010, 1, H0,  0, 0, "rr_1");
    vec(1, 4'b0000, H0,  H1,  H2,  H3,  4'b0000, 4'b0100, 1, H1,  1, 1, "rr_2");
    vec(1, 4'b0000, H0,  H1,  H2,  H3,  4'b0000, 4'b1000, 1, H2,  2, 2, "rr_3");
    vec(1, 4'b0000, H0,  H1,  H2,  H3,  4'b0000, 4'b0001, 1, H3,  3, 3, "rr_wrap");
    vec(1, 4'b1011, H0,  H1,  W28, H3,  4'b1111, 4'b0100, 1, H0,  0, 0, "single_a");
    vec(1, 4'b1011, H0,  H1,  W28, H3,  4'b1111, 4'b0100, 1, W28, 2, 2, "single_b");
    vec(1, 4'b1011, H0,  H1,  W28, H3,  4'b1111, 4'b0100, 1, W28, 2, 2, "single_c");
    vec(1, 4'b0111, H0,  H1,  H2,  W29, 4'b0000, 4'b1000, 1, W28, 2, 2, "grant_29");
    vec(1, 4'b1111, H0,  H1,  H2,  W29, 4'b0000, 4'b0000, 1, W29, 2, 3, "idle_a");
    vec(1, 4'b1111, H0,  H1,  H2,  W29, 4'b0000, 4'b0000, 0, W29, 2, 3, "idle_b");
    vec(1, 4'b0000, H0,  H1,  H2,  H3,  4'b0000, 4'b0001, 0, W29, 2, 3, "ptr_held");
    vec(1, 4'b0000, H0,  H1,  H2,  H3,  4'b0000, 4'b0010, 1, H0,  0, 0, "pre_rst");
    vec(0, 4'b0000, H0,  H1,  H2,  H3,  4'b0000, 4'b0000, 1, H1,  1, 1, "mid_rst");
    vec(1, 4'b0000, H0,  H1,  H2,  H3,  4'b0000, 4'b0001, 0, H0,  0, 0, "post_rst");
    vec(1, 4'b0111, H0,  H1,  H2,  H3,  4'b0000, 4'b1000, 1, H0,  0, 0, "to_ptr3");
`ifdef RR_BACKPRESSURE_EN
    vec(1, 4'b1100, B0,  B1,  H2,  H3,  4'b1000, 4'b0010, 1, H3,  3, 3, "bp_skip");
    vec(1, 4'b1111, B0,  B1,  H2,  H3,  4'b1000, 4'b0000, 1, B1,  0, 1, "bp_after");
`else
    vec(1, 4'b1100, B0,  B1,  H2,  H3,  4'b1000, 4'b0001, 1, H3,  3, 3, "bp_ignored");
    vec(1, 4'b1111, B0,  B1,  H2,  H3,  4'b1000, 4'b0000, 1, B0,  3, 0, "bp_after");
`endif

    drained = 1'b0;
    for (int i = 0; i < 20 && !drained; i++) begin
      @(negedge clk);
      #1;
      if (sb_q.size() == 0) drained = 1'b1;
    end
    n_checks++;
    if (!drained) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/round_robin_src_4x1.md
ROUND_ROBIN_SRC_4X1 -- requirements
Module: round_robin_src_4x1

Interface
REQ-001 The block SHALL have these ports: clk  input  1  sole clock, all logic on rising edge.
REQ-002 reset  input  1  synchronous, active-low reset; reset==0 at a rising clk edge resets the block.
REQ-003 fifo_empty  input  4  empty flag of input FIFO i, bit i.
REQ-004 fifo_data_0..fifo_data_3  input  10 each  show-ahead head word of input FIFO i; bits [9:8] = destination.
REQ-005 dest_almost_full  input  4  almost-full flag of downstream FIFO_0..FIFO_3, bit j.
REQ-006 fifo_pop  output  4  one-hot-or-zero pop strobe to input FIFO i, combinational.
REQ-007 demuxIn  output  10  registered word for the downstream demux_4x1.
REQ-008 select  output  2  registered demux select, equal to demuxIn[9:8].
REQ-009 valid  output  1  registered; demuxIn/select carry a new word this cycle.
REQ-010 grant_id  output  2  registered index of the input FIFO that supplied the current word.

Function
REQ-011 State: 2-bit pointer last_grant; priority order SHALL be last_grant+1, +2, +3, +4 (mod 4).
REQ-012 Input i SHALL be eligible when fifo_empty[i]==0, subject to REQ-024.
REQ-013 The first eligible input in priority order SHALL be granted; fifo_pop SHALL assert only its bit in that same cycle.
REQ-014 At most one fifo_pop bit SHALL be high in any cycle.
REQ-015 On a grant, at the next rising edge: demuxIn<=fifo_data_i, select<=fifo_data_i[9:8], grant_id<=i, valid<=1, last_grant<=i (latency 1 cycle pop->valid).
REQ-016 With no eligible input: fifo_pop==0, valid<=0, last_grant unchanged; demuxIn, select, grant_id SHALL hold their previous values.
REQ-017 Back-to-back grants SHALL be allowed every cycle (throughput 1 word/cycle).
REQ-018 With all four inputs continuously eligible, grants SHALL cycle 0,1,2,3,0,... with no input granted twice before every other eligible input is granted once.
REQ-019 Pointer wrap: last_grant==3 SHALL give priority order 0,1,2,3.
REQ-020 A single eligible input SHALL be granted every cycle (no bubble).

Reset
REQ-021 While reset==0 at a rising edge: last_grant<=3, demuxIn<=0, select<=0, valid<=0, grant_id<=0.
REQ-022 While reset==0, fifo_pop SHALL be forced to 4'b0000 regardless of inputs.
REQ-023 Reset asserted mid-stream SHALL discard any in-flight output (valid 0 next cycle); first grant after release SHALL start from input 0 priority.

Configuration
REQ-024 Macro RR_BACKPRESSURE_EN defined: input i additionally SHALL be eligible only if dest_almost_full[fifo_data_i[9:8]]==0; blocked inputs are skipped, not stalled on.
REQ-025 Macro RR_BACKPRESSURE_EN undefined: dest_almost_full SHALL be ignored; eligibility per REQ-012 only.

Verification
REQ-026 Reset held low 2 cycles, all FIFOs non-empty -> fifo_pop==0, valid==0, demuxIn==0; after release first pop 4'b0001.
REQ-027 All fifo_empty==0, heads 10'h000/10'h100/10'h200/10'h300 -> pops 0001,0010,0100,1000,0001; next-cycle select 0,1,2,3,0, valid held 1.
REQ-028 Only FIFO 2 non-empty, head 10'b1001111001 for 3 cycles -> fifo_pop==0100 each cycle; demuxIn==10'b1001111001, select==2'b10, grant_id==2.
REQ-029 All fifo_empty==1 after a grant of 10'b1011001100 -> fifo_pop==0, valid==0, demuxIn holds 10'b1011001100, pointer unchanged.
REQ-030 RR_BACKPRESSURE_EN defined, FIFO 0 head dest 3, dest_almost_full==4'b1000, FIFO 1 head dest 0 -> FIFO 0 skipped, pop 0010; undefined -> pop 0001.
REQ-031 Reset asserted one cycle during continuous grant sequence at last_grant==1 -> pop 0000, valid 0 next cycle; after release pop 0001.
